// File: rtl/pi.sv
// PI controller: full-precision products, guarded integrator, one-clock latency, saturated output.
// Optional integrator anti-windup is selected with the PI_ANTIWINDUP_EN macro.
module pi #(
  parameter int                        NB_DATA      = 16,
  parameter int                        NB_COEF      = 16,
  parameter int                        NB_FRAC_COEF = 14,
  parameter logic signed [NB_COEF-1:0] KP           = 16'sh4000,
  parameter logic signed [NB_COEF-1:0] KI           = 16'sh0400,
  parameter int                        NB_GUARD     = 8
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic signed [NB_DATA-1:0] i_data,
  output logic signed [NB_DATA-1:0] o_data
);

  localparam int NB_PROD = NB_DATA + NB_COEF;
  localparam int NB_INT  = NB_PROD + NB_GUARD;
  localparam int NB_SUM  = NB_INT + 1;

  // Clamp a one-bit-wider sum back into the integrator range.
  function automatic logic signed [NB_INT-1:0] sat_int(input logic signed [NB_INT:0] v);
    logic signed [NB_INT-1:0] r;
    if (v[NB_INT] != v[NB_INT-1]) begin
      if (v[NB_INT]) r = {1'b1, {(NB_INT-1){1'b0}}};
      else           r = {1'b0, {(NB_INT-1){1'b1}}};
    end else begin
      r = v[NB_INT-1:0];
    end
    return r;
  endfunction

  function automatic logic signed [NB_DATA-1:0] sat_out(input logic signed [NB_SUM-1:0] v);
    logic [NB_SUM-NB_DATA:0]   hi;
    logic signed [NB_DATA-1:0] r;
    hi = v[NB_SUM-1:NB_DATA-1];
    if ((&hi) || (~|hi)) begin
      r = v[NB_DATA-1:0];
    end else if (v[NB_SUM-1]) begin
      r = {1'b1, {(NB_DATA-1){1'b0}}};
    end else begin
      r = {1'b0, {(NB_DATA-1){1'b1}}};
    end
    return r;
  endfunction

`ifdef PI_ANTIWINDUP_EN
  localparam logic signed [NB_INT-1:0] LIM_HI =
    {{(NB_INT-NB_DATA-NB_FRAC_COEF){1'b0}}, 1'b0, {(NB_DATA-1){1'b1}}, {NB_FRAC_COEF{1'b0}}};
  localparam logic signed [NB_INT-1:0] LIM_LO =
    {{(NB_INT-NB_DATA-NB_FRAC_COEF+1){1'b1}}, {(NB_DATA-1){1'b0}}, {NB_FRAC_COEF{1'b0}}};

  function automatic logic signed [NB_INT-1:0] clamp_aw(input logic signed [NB_INT-1:0] v);
    logic signed [NB_INT-1:0] r;
    if (v > LIM_HI)      r = LIM_HI;
    else if (v < LIM_LO) r = LIM_LO;
    else                 r = v;
    return r;
  endfunction
`endif

  logic signed [NB_INT-1:0]  r_int;
  logic signed [NB_DATA-1:0] r_out;

  logic signed [NB_PROD-1:0] w_e_ext;
  logic signed [NB_PROD-1:0] w_kp_ext;
  logic signed [NB_PROD-1:0] w_ki_ext;
  logic signed [NB_PROD-1:0] w_p;
  logic signed [NB_PROD-1:0] w_q;
  logic signed [NB_INT:0]    w_acc;
  logic signed [NB_INT-1:0]  w_int_new;
  logic signed [NB_SUM-1:0]  w_y;
  logic signed [NB_SUM-1:0]  w_shift;
  logic signed [NB_DATA-1:0] w_out;

  // Operands are widened to product width first so the products never truncate.
  assign w_e_ext  = {{NB_COEF{i_data[NB_DATA-1]}}, i_data};
  assign w_kp_ext = {{NB_DATA{KP[NB_COEF-1]}}, KP};
  assign w_ki_ext = {{NB_DATA{KI[NB_COEF-1]}}, KI};
  assign w_p      = w_kp_ext * w_e_ext;
  assign w_q      = w_ki_ext * w_e_ext;

  assign w_acc = {r_int[NB_INT-1], r_int} + {{(NB_GUARD+1){w_q[NB_PROD-1]}}, w_q};

`ifdef PI_ANTIWINDUP_EN
  assign w_int_new = clamp_aw(sat_int(w_acc));
`else
  assign w_int_new = sat_int(w_acc);
`endif

  assign w_y     = {w_int_new[NB_INT-1], w_int_new} + {{(NB_GUARD+1){w_p[NB_PROD-1]}}, w_p};
  assign w_shift = w_y >>> NB_FRAC_COEF;
  assign w_out   = sat_out(w_shift);

  // Integrator and output registers; reset overrides the current sample.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_int <= {NB_INT{1'b0}};
      r_out <= {NB_DATA{1'b0}};
    end else begin
      r_int <= w_int_new;
      r_out <= w_out;
    end
  end

  assign o_data = r_out;

endmodule

// File: tb/tb_pi.sv
// Scoreboard bench for pi: five gain configurations share clock and reset; a
// behavioural model pushes expected outputs, a monitor pops and compares each cycle.
module tb_pi;

  localparam int NDUT = 5;

  logic               clk;
  logic               rst;
  logic signed [15:0] din  [NDUT];
  logic signed [15:0] dout [NDUT];

  longint             kp    [NDUT];
  longint             ki    [NDUT];
  longint             integ [NDUT];
  logic signed [15:0] exp_q [NDUT][$];

  int  n_checks;
  int  n_pass;
  bit  done;

  pi #(.KP(16'sh4000), .KI(16'sh0400)) u_dflt (.i_clk(clk), .i_rst(rst), .i_data(din[0]), .o_data(dout[0]));
  pi #(.KP(16'sh4000), .KI(16'sh0000)) u_p1   (.i_clk(clk), .i_rst(rst), .i_data(din[1]), .o_data(dout[1]));
  pi #(.KP(16'sh2000), .KI(16'sh0000)) u_p05  (.i_clk(clk), .i_rst(rst), .i_data(din[2]), .o_data(dout[2]));
  pi #(.KP(16'sh0000), .KI(16'sh4000)) u_i1   (.i_clk(clk), .i_rst(rst), .i_data(din[3]), .o_data(dout[3]));
  pi #(.KP(16'sh7FFF), .KI(16'sh0000)) u_pmax (.i_clk(clk), .i_rst(rst), .i_data(din[4]), .o_data(dout[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour from plain integer arithmetic on 64-bit values.
  function automatic logic signed [15:0] model_step(input int k, input bit r, input logic signed [15:0] e);
    longint ev, y, s;
    longint int_max, int_min;
    int_max = (64'sd1 <<< 39) - 64'sd1;
    int_min = -(64'sd1 <<< 39);
    if (r) begin
      integ[k] = 64'sd0;
      return 16'sd0;
    end
    ev = longint'(e);
    integ[k] = integ[k] + ki[k] * ev;
    if (integ[k] > int_max) integ[k] = int_max;
    if (integ[k] < int_min) integ[k] = int_min;
`ifdef PI_ANTIWINDUP_EN
    if (integ[k] > (64'sd32767 <<< 14))  integ[k] = 64'sd32767 <<< 14;
    if (integ[k] < -(64'sd32768 <<< 14)) integ[k] = -(64'sd32768 <<< 14);
`endif
    y = kp[k] * ev + integ[k];
    s = y >>> 14;
    if (s > 64'sd32767)  s = 64'sd32767;
    if (s < -64'sd32768) s = -64'sd32768;
    return 16'(s);
  endfunction

  function automatic logic signed [15:0] rnd_sample();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)      return 16'sh7FFF;
    else if (sel == 1) return 16'sh8000;
    else if (sel == 2) return 16'sh0000;
    else               return 16'($urandom);
  endfunction

  task automatic drive(input bit r, input logic signed [15:0] d0, input logic signed [15:0] d1,
                       input logic signed [15:0] d2, input logic signed [15:0] d3,
                       input logic signed [15:0] d4);
    logic signed [15:0] d [NDUT];
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3; d[4] = d4;
    @(negedge clk);
    rst = r;
    for (int k = 0; k < NDUT; k++) begin
      din[k] = d[k];
      exp_q[k].push_back(model_step(k, r, d[k]));
    end
  endtask

  // Monitor: every post-edge sample is a valid output for every instance.
  initial begin
    n_checks = 0;
    n_pass   = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        if (exp_q[k].size() > 0) begin
          logic signed [15:0] e;
          e = exp_q[k].pop_front();
          n_checks++;
          if (dout[k] === e) n_pass++;
          else $display("FAIL out[%0d] t=%0t got %h want %h", k, $time, dout[k], e);
        end
      end
    end
  end

  initial begin
    done = 1'b0;
    kp[0] = 64'sd16384; ki[0] = 64'sd1024;
    kp[1] = 64'sd16384; ki[1] = 64'sd0;
    kp[2] = 64'sd8192;  ki[2] = 64'sd0;
    kp[3] = 64'sd0;     ki[3] = 64'sd16384;
    kp[4] = 64'sd32767; ki[4] = 64'sd0;
    for (int k = 0; k < NDUT; k++) begin
      integ[k] = 64'sd0;
      din[k]   = 16'sh0000;
    end
    rst = 1'b1;

    // Long reset with non-zero input, then first samples after release.
    for (int c = 0; c < 25; c++)
      drive(1'b1, 16'sh1234, 16'sh1234, 16'sh1234, 16'sh1234, 16'sh1234);
    drive(1'b0, rnd_sample(), 16'sh1000, 16'sh1000, 16'sh0100, 16'sh7FFF);
    for (int c = 0; c < 20; c++)
      drive(1'b0, rnd_sample(), 16'sh1000, 16'sh1000, 16'sh0100, (c % 2 == 0) ? 16'sh8000 : 16'sh7FFF);

    // Reset mid-operation, then windup sequence on the integral-only instance.
    drive(1'b1, rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample(), rnd_sample());
    for (int c = 0; c < 10; c++)
      drive(1'b0, rnd_sample(), rnd_sample(), rnd_sample(), 16'sh4000, rnd_sample());
    for (int c = 0; c < 20; c++)
      drive(1'b0, rnd_sample(), rnd_sample(), rnd_sample(), 16'shC000, rnd_sample());

    // Sustained negative extreme drives the integrator into its own width limit.
    for (int c = 0; c < 1100; c++)
      drive(1'b0, rnd_sample(), rnd_sample(), rnd_sample(), 16'sh8000, rnd_sample());
    for (int c = 0; c < 40; c++)
      drive(1'b0, rnd_sample(), rnd_sample(), rnd_sample(), 16'sh7FFF, rnd_sample());

    // Random regression on all instances, with occasional resets.
    for (int c = 0; c < 1024; c++)
      drive(($urandom_range(0, 199) == 0), rnd_sample(), rnd_sample(), rnd_sample(),
            rnd_sample(), rnd_sample());

    @(negedge clk);
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      n_checks++;
      if (exp_q[k].size() == 0) n_pass++;
      else $display("FAIL drain[%0d] left %0d want 0", k, exp_q[k].size());
    end
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
